stencil_window_gen: RTL and testbench

Parametrised streaming window generator for the SODA stencil datapath. Accepts a row-major image as beats of `ST` elements and emits, per beat, the full `K`×(`ST`+`K`-1) neighbourhood that `ST` stencil lanes need. It generalises the fixed 3×3 front end to any odd kernel size `K` and adds output backpressure, per-lane valid masks and end-of-frame marking. It sits between the input stream and the MAC/PE array.

---
 rtl/soda_pkg.sv | 22 ++
 rtl/soda_line_buffer.sv | 22 ++
 rtl/stencil_window_gen.sv | 125 ++++++++++++
 tb/tb_stencil_window_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soda_pkg.sv
// Shared types and sizing helpers for the SODA stencil front end.
package soda_pkg;

  localparam int unsigned BW_DFLT = 32;
  localparam int unsigned ST_DFLT = 4;

  typedef logic [BW_DFLT-1:0] elem_t;
  typedef elem_t [ST_DFLT-1:0] beat_t;

  function automatic int unsigned win_cols(input int unsigned st, input int unsigned k);
    return st + k - 1;
  endfunction

  function automatic int unsigned beats_per_row(input int unsigned col, input int unsigned st);
    return col / st;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soda_line_buffer.sv
// One row of beats; read and write share the address so a fire shifts the entry down a row.
module soda_line_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/stencil_window_gen.sv
// Streaming K x (ST+K-1) window generator with backpressure, lane masks and end-of-frame flag.
module stencil_window_gen
  import soda_pkg::*;
#(
  parameter int unsigned BW  = 32,
  parameter int unsigned ST  = 4,
  parameter int unsigned K   = 3,
  parameter int unsigned ROW = 64,
  parameter int unsigned COL = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [ST*BW-1:0]           io_in_matrix,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [K*(ST+K-1)*BW-1:0]   io_out_window,
  output logic [ST-1:0]              io_out_mask,
  output logic                       io_out_last
);

  localparam int unsigned BPR = beats_per_row(COL, ST);
  localparam int unsigned WC  = win_cols(ST, K);
  localparam int unsigned BAW = cnt_width(BPR);
  localparam int unsigned RAW = cnt_width(ROW);
  localparam int unsigned CW  = (K-1)*BW;
  localparam int unsigned RW  = WC*BW;
  localparam int unsigned WW  = K*RW;

  logic [BAW-1:0]   b_q, b_d;
  logic [RAW-1:0]   r_q, r_d;
  logic             valid_q, valid_d;
  logic [WW-1:0]    window_q, window_d;
  logic [ST-1:0]    mask_q, mask_d;
  logic             last_q, last_d;
  logic [CW-1:0]    carry_q [K];
  logic [CW-1:0]    carry_d [K];
  logic [ST*BW-1:0] rd [K-1];
  logic [ST*BW-1:0] rows [K];
  logic             in_fire;

  assign io_in_ready = !valid_q | io_out_ready;
  assign in_fire     = io_in_valid & io_in_ready;

  // Buffer g holds row r-1-g; the chain shifts one row older on every fire.
  for (genvar g = 0; g < K-1; g++) begin : g_lb
    soda_line_buffer #(
      .DEPTH (BPR),
      .WIDTH (ST*BW),
      .AW    (BAW)
    ) u_lb (
      .clock (clock),
      .we    (in_fire),
      .addr  (b_q),
      .wdata ((g == 0) ? io_in_matrix : rd[g-1]),
      .rdata (rd[g])
    );
  end

  always_comb begin
    rows[K-1] = io_in_matrix;
    for (int unsigned j = 0; j < K-1; j++) rows[j] = rd[K-2-j];
  end

  always_comb begin
    b_d      = b_q;
    r_d      = r_q;
    valid_d  = valid_q;
    window_d = window_q;
    mask_d   = mask_q;
    last_d   = last_q;
    for (int unsigned j = 0; j < K; j++) carry_d[j] = carry_q[j];

    if (in_fire) begin
      if (b_q == BAW'(BPR-1)) begin
        b_d = '0;
        r_d = (r_q == RAW'(ROW-1)) ? '0 : r_q + RAW'(1);
      end else begin
        b_d = b_q + BAW'(1);
      end
      for (int unsigned j = 0; j < K; j++) carry_d[j] = rows[j][CW-1:0];

      // Rows above K-1 only; earlier rows are consumed to fill the line buffers.
      valid_d = (r_q >= RAW'(K-1));
      if (valid_d) begin
        for (int unsigned j = 0; j < K; j++)
          window_d[(K-1-j)*RW +: RW] = {((b_q == '0) ? {CW{1'b0}} : carry_q[j]), rows[j]};
        mask_d = '1;
        if (b_q == '0) mask_d[ST-1 -: K-1] = '0;
        last_d = (r_q == RAW'(ROW-1)) && (b_q == BAW'(BPR-1));
      end
    end else if (io_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      b_q      <= '0;
      r_q      <= '0;
      valid_q  <= 1'b0;
      window_q <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      b_q      <= b_d;
      r_q      <= r_d;
      valid_q  <= valid_d;
      window_q <= window_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned j = 0; j < K; j++) carry_q[j] <= carry_d[j];
  end

  assign io_out_valid  = valid_q;
  assign io_out_window = window_q;
  assign io_out_mask   = mask_q;
  assign io_out_last   = last_q;

endmodule

// File: tb/tb_stencil_window_gen.sv
// Directed bench for stencil_window_gen on a 6x8 image, ST=4, K=3.
module tb_stencil_window_gen;

  localparam int BW = 32, ST = 4, K = 3, ROW = 6, COL = 8;
  localparam int WW = K*(ST+K-1)*BW;
  localparam int NB = ROW*COL/ST;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [ST*BW-1:0] in_matrix;
  logic            out_valid, out_ready;
  logic [WW-1:0]   out_window;
  logic [ST-1:0]   out_mask;
  logic            out_last;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] q_win[$];
  logic [ST-1:0] q_mask[$];
  logic          q_last[$];

  stencil_window_gen #(.BW(BW), .ST(ST), .K(K), .ROW(ROW), .COL(COL)) dut (
    .clock         (clk),
    .reset         (reset),
    .io_in_valid   (in_valid),
    .io_in_ready   (in_ready),
    .io_in_matrix  (in_matrix),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_window (out_window),
    .io_out_mask   (out_mask),
    .io_out_last   (out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_win.push_back(out_window);
      q_mask.push_back(out_mask);
      q_last.push_back(out_last);
    end
  end

  function automatic logic [31:0] pix(input int tag, input int row, input int col);
    return 32'(tag*256 + row*16 + col);
  endfunction

  function automatic logic [ST*BW-1:0] beat(input int tag, input int n);
    logic [ST*BW-1:0] m;
    for (int i = 0; i < ST; i++) m[(ST-1-i)*BW +: BW] = pix(tag, n/2, (n%2)*ST + i);
    return m;
  endfunction

  // Expected window for input beat b of row r: columns b*ST-2 .. b*ST+3 of rows r-2 .. r.
  function automatic logic [WW-1:0] gold_win(input int tag, input int r, input int b);
    logic [WW-1:0] w;
    int col;
    for (int j = 0; j < K; j++)
      for (int i = 0; i < ST+K-1; i++) begin
        col = b*ST - (K-1) + i;
        w[(K*(ST+K-1)-1-(j*(ST+K-1)+i))*BW +: BW] = (col < 0) ? 32'h0 : pix(tag, r-K+1+j, col);
      end
    return w;
  endfunction

  function automatic logic [ST-1:0] gold_mask(input int b);
    return (b == 0) ? 4'b0011 : 4'b1111;
  endfunction

  task automatic clear_q();
    q_win.delete(); q_mask.delete(); q_last.delete();
  endtask

  task automatic send_frame(input int tag, input int first, input int last_excl,
                            input bit rnd, input bit drain);
    int  n = first;
    int  guard = 0;
    bit  fire;
    while (n < last_excl && guard < 4000) begin
      guard++;
      in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_matrix = beat(tag, n);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) n++;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== last_excl) begin
      errors++;
      $display("FAIL send_timeout tag %0d sent %0d beats, required %0d", tag, n, last_excl);
    end
    if (drain) begin
      guard = 0;
      while (out_valid && guard < 4000) begin
        guard++;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_timeout tag %0d out_valid still %b", tag, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_matrix = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_window !== '0 || out_mask !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid %b mask %b last %b win_nonzero %b, required all 0",
               out_valid, out_mask, out_last, |out_window);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready %b out_valid %b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_stream();
    logic [6*BW-1:0] exp_top0, exp_top1, exp_bot1;
    exp_top0 = {32'h0, 32'h0, 32'h00, 32'h01, 32'h02, 32'h03};
    exp_top1 = {32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07};
    exp_bot1 = {32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27};
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < NB; k++) begin
      in_valid = 1'b1; in_matrix = beat(0, k);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready beat %0d got %b required 1", k, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== (k >= 4)) begin
        errors++; $display("FAIL stream_valid beat %0d got %b required %b", k, out_valid, k >= 4);
      end
      checks++;
      if (k >= 4 && out_last !== (k == NB-1)) begin
        errors++; $display("FAIL stream_last beat %0d got %b required %b", k, out_last, k == NB-1);
      end
      if (k == 4) begin
        checks++;
        if (out_mask !== 4'b0011 || out_window[WW-1 -: 6*BW] !== exp_top0) begin
          errors++;
          $display("FAIL first_window mask %b top %h, required 0011 %h", out_mask, out_window[WW-1 -: 6*BW], exp_top0);
        end
      end
      if (k == 5) begin
        checks++;
        if (out_mask !== 4'b1111 || out_window[WW-1 -: 6*BW] !== exp_top1 || out_window[6*BW-1:0] !== exp_bot1) begin
          errors++;
          $display("FAIL second_window mask %b top %h bot %h, required 1111 %h %h", out_mask,
                   out_window[WW-1 -: 6*BW], out_window[6*BW-1:0], exp_top1, exp_bot1);
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q_win.size() !== 8) begin
      errors++; $display("FAIL stream_count got %0d required 8", q_win.size());
    end
    for (int i = 0; i < 8 && i < q_win.size(); i++) begin
      checks++;
      if (q_win[i] !== gold_win(0, 2+i/2, i%2) || q_mask[i] !== gold_mask(i%2) || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL stream_win%0d got %h m%b l%b required %h m%b l%b", i, q_win[i], q_mask[i], q_last[i],
                 gold_win(0, 2+i/2, i%2), gold_mask(i%2), i == 7);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] snap_w;
    logic [ST-1:0] snap_m;
    clear_q();
    send_frame(2, 0, 5, 1'b0, 1'b0);
    in_valid = 1'b1; in_matrix = beat(2, 5); out_ready = 1'b0;
    snap_w = out_window; snap_m = out_mask;
    checks++;
    if (out_valid !== 1'b1 || snap_w !== gold_win(2, 2, 0)) begin
      errors++; $display("FAIL bp_pre valid %b win %h required 1 %h", out_valid, snap_w, gold_win(2, 2, 0));
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_window !== snap_w || out_mask !== snap_m) begin
        errors++;
        $display("FAIL bp_hold cycle %0d in_ready %b valid %b mask %b win %h, required 0 1 %b %h",
                 c, in_ready, out_valid, out_mask, out_window, snap_m, snap_w);
      end
      @(posedge clk); #1;
    end
    send_frame(2, 5, NB, 1'b0, 1'b1);
    checks++;
    if (q_win.size() !== 8) begin
      errors++; $display("FAIL bp_count got %0d required 8", q_win.size());
    end
    for (int i = 0; i < 8 && i < q_win.size(); i++) begin
      checks++;
      if (q_win[i] !== gold_win(2, 2+i/2, i%2) || q_mask[i] !== gold_mask(i%2) || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL bp_win%0d got %h m%b l%b required %h", i, q_win[i], q_mask[i], q_last[i], gold_win(2, 2+i/2, i%2));
      end
    end
  endtask

  task automatic test_random();
    int lasts;
    for (int f = 0; f < 3; f++) begin
      clear_q();
      send_frame(3+f, 0, NB, 1'b1, 1'b1);
      checks++;
      if (q_win.size() !== 8) begin
        errors++; $display("FAIL rnd_count frame %0d got %0d required 8", f, q_win.size());
      end
      lasts = 0;
      for (int i = 0; i < 8 && i < q_win.size(); i++) begin
        if (q_last[i] === 1'b1) lasts++;
        checks++;
        if (q_win[i] !== gold_win(3+f, 2+i/2, i%2) || q_mask[i] !== gold_mask(i%2) || q_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL rnd_win f%0d i%0d got %h m%b l%b required %h", f, i, q_win[i], q_mask[i], q_last[i],
                   gold_win(3+f, 2+i/2, i%2));
        end
      end
      checks++;
      if (lasts !== 1) begin
        errors++; $display("FAIL rnd_last_count frame %0d got %0d required 1", f, lasts);
      end
    end
  endtask

  task automatic test_frame_wrap();
    int tag;
    clear_q();
    send_frame(6, 0, NB, 1'b0, 1'b0);
    send_frame(7, 0, NB, 1'b0, 1'b1);
    checks++;
    if (q_win.size() !== 16) begin
      errors++; $display("FAIL wrap_count got %0d required 16", q_win.size());
    end
    for (int i = 0; i < 16 && i < q_win.size(); i++) begin
      tag = (i < 8) ? 6 : 7;
      checks++;
      if (q_win[i] !== gold_win(tag, 2+(i%8)/2, i%2) || q_mask[i] !== gold_mask(i%2) || q_last[i] !== (i%8 == 7)) begin
        errors++;
        $display("FAIL wrap_win%0d got %h m%b l%b required %h", i, q_win[i], q_mask[i], q_last[i],
                 gold_win(tag, 2+(i%8)/2, i%2));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8, 0, 7, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_window !== '0 || out_mask !== '0) begin
      errors++; $display("FAIL midreset_outputs valid %b mask %b, required 0 0", out_valid, out_mask);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    clear_q();
    send_frame(9, 0, NB, 1'b0, 1'b1);
    checks++;
    if (q_win.size() !== 8) begin
      errors++; $display("FAIL midreset_count got %0d required 8", q_win.size());
    end
    for (int i = 0; i < 8 && i < q_win.size(); i++) begin
      checks++;
      if (q_win[i] !== gold_win(9, 2+i/2, i%2) || q_mask[i] !== gold_mask(i%2) || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL midreset_win%0d got %h m%b l%b required %h", i, q_win[i], q_mask[i], q_last[i], gold_win(9, 2+i/2, i%2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_frame_wrap();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
